alu_op_scheduler: RTL

//  Shares the single two-lane ALU (add/sub/mul/div/shr/shl, real or complex) among NUM_REQ requesters.

---
 rtl/alu_sched_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/alu_op_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg
//   Shared constants for the ALU operation scheduler: ALU opcode encodings,
//   the "no operation" chooser value, the highest legal opcode and the
//   scheduler FSM state encoding.
package alu_sched_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_RSH  = 3'd4;
  localparam logic [2:0] OP_LSH  = 3'd5;
  localparam logic [2:0] OP_NONE = 3'b111;

  localparam logic [2:0] OP_LEGAL_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker: grants the first asserted request at or
//   after ptr, wrapping cyclically.
// Ports
//   req        in   NUM_REQ  request vector
//   ptr        in   PTR_W    index with highest priority this cycle
//   grant      out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx  out  PTR_W    encoded index of the granted request
//   any        out  1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_v;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = PTR_W'(idx);
      if (!any && req[idx_v]) begin
        any          = 1'b1;
        grant[idx_v] = 1'b1;
        grant_idx    = idx_v;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Shares one two-lane ALU among NUM_REQ requesters with round-robin
//   arbitration, one operation in flight. Operands are held on the ALU for
//   ALU_LATENCY cycles, the result is captured and returned on a single
//   valid/ready response port tagged with the requester id.
//   Optional feature macro: ALU_SCHED_STATS_EN adds per-requester completion
//   counters on done_cnt.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (ready one-hot or zero)
//   req_op/cplx/a/b/ai/bi      per-requester packed payload
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/y1/y2/err           response payload
//   alu_chooser/is_complex/a/b/ai/bi   drive to the ALU (chooser 3'b111 = idle)
//   alu_y1/alu_y2              results from the ALU
//   done_cnt                   per-requester completions (ALU_SCHED_STATS_EN)
//
// state | meaning
// IDLE  | arbitrate; accept the granted request
// EXEC  | ALU operands held, latency counter running down
// RESP  | response presented until rsp_ready
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ALU_LATENCY = 3,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_op,
  input  logic [NUM_REQ-1:0]    req_cplx,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [16*NUM_REQ-1:0] req_ai,
  input  logic [16*NUM_REQ-1:0] req_bi,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_y1,
  output logic [31:0]           rsp_y2,
  output logic                  rsp_err,
  output logic [2:0]            alu_chooser,
  output logic                  alu_is_complex,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [15:0]           alu_ai,
  output logic [15:0]           alu_bi,
  input  logic [31:0]           alu_y1,
  input  logic [31:0]           alu_y2
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [CNT_W*NUM_REQ-1:0] done_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAT_W = $clog2(ALU_LATENCY + 1);

  sched_state_t       state_q, state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   g_idx;
  logic               arb_any;

  logic [2:0]  op_arr [NUM_REQ];
  logic [15:0] a_arr  [NUM_REQ];
  logic [15:0] b_arr  [NUM_REQ];
  logic [15:0] ai_arr [NUM_REQ];
  logic [15:0] bi_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[3*i +: 3];
    assign a_arr[i]  = req_a[16*i +: 16];
    assign b_arr[i]  = req_b[16*i +: 16];
    assign ai_arr[i] = req_ai[16*i +: 16];
    assign bi_arr[i] = req_bi[16*i +: 16];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (g_idx),
    .any       (arb_any)
  );

  // Grant only in IDLE; since grant is one-hot among valid requesters, an
  // accept in IDLE is exactly arb_any.
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign rsp_valid = (state_q == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (arb_any) state_d = op_is_legal(op_arr[g_idx]) ? ST_EXEC : ST_RESP;
      ST_EXEC: if (lat_cnt_q == LAT_W'(1)) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q          <= '0;
      lat_cnt_q      <= '0;
      rsp_id         <= '0;
      rsp_y1         <= '0;
      rsp_y2         <= '0;
      rsp_err        <= 1'b0;
      alu_chooser    <= OP_NONE;
      alu_is_complex <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ai         <= '0;
      alu_bi         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            ptr_q  <= (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
            rsp_id <= ID_W'(g_idx);
            if (op_is_legal(op_arr[g_idx])) begin
              rsp_err        <= 1'b0;
              lat_cnt_q      <= LAT_W'(ALU_LATENCY);
              alu_chooser    <= op_arr[g_idx];
              alu_is_complex <= req_cplx[g_idx];
              alu_a          <= a_arr[g_idx];
              alu_b          <= b_arr[g_idx];
              alu_ai         <= ai_arr[g_idx];
              alu_bi         <= bi_arr[g_idx];
            end else begin
              // Illegal op never reaches the ALU; answer immediately with zeros.
              rsp_err <= 1'b1;
              rsp_y1  <= '0;
              rsp_y2  <= '0;
            end
          end
        end
        ST_EXEC: begin
          if (lat_cnt_q == LAT_W'(1)) begin
            rsp_y1 <= alu_y1;
            rsp_y2 <= alu_y2;
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) alu_chooser <= OP_NONE;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else if (state_q == ST_RESP && rsp_ready && rsp_id == ID_W'(i)) cnt_q <= cnt_q + 1'b1;
    end
    assign done_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
